// File: rtl/count_monitor.sv
// rtl/count_monitor.sv - classifies 3-bit up/down counter bus changes into steps and illegal jumps.
// Optional glitch filter (third sync stage + stability check) enabled by MONITOR_DEBOUNCE_EN.
module count_monitor #(
  parameter int POS_W    = 16,
  parameter int ERRCNT_W = 8
) (
  input  logic                       clkin,
  input  logic                       reset,
  input  logic                       x0,
  input  logic                       x1,
  input  logic                       x2,
  input  logic                       clr,
  output logic                       up_step,
  output logic                       down_step,
  output logic                       dir_out,
  output logic signed [POS_W-1:0]    pos,
  output logic                       fault,
  output logic [ERRCNT_W-1:0]        err_cnt
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_TRACK,
    ST_FAULT
  } state_t;

`ifdef MONITOR_DEBOUNCE_EN
  localparam logic [1:0] FILL_LAST = 2'd2;
`else
  localparam logic [1:0] FILL_LAST = 2'd1;
`endif

  state_t                state_q, state_d;
  logic [1:0]            fill_q, fill_d;
  logic [2:0]            s1_q, s1_d;
  logic [2:0]            s2_q, s2_d;
`ifdef MONITOR_DEBOUNCE_EN
  logic [2:0]            s3_q, s3_d;
`endif
  logic [2:0]            prev_q, prev_d;
  logic                  up_q, up_d;
  logic                  down_q, down_d;
  logic                  dir_q, dir_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic                  fault_q, fault_d;
  logic [ERRCNT_W-1:0]   err_q, err_d;

  logic [2:0]            code;
  logic [2:0]            delta;
  logic                  code_ok;

  always_comb begin
    s1_d = {x2, x1, x0};
    s2_d = s1_q;
    code = s2_q;
`ifdef MONITOR_DEBOUNCE_EN
    s3_d    = s2_q;
    code_ok = (s2_q == s3_q);
`else
    code_ok = 1'b1;
`endif
    delta = code - prev_q;

    state_d = state_q;
    fill_d  = fill_q;
    prev_d  = prev_q;
    up_d    = 1'b0;
    down_d  = 1'b0;
    dir_d   = dir_q;
    pos_d   = pos_q;
    fault_d = fault_q;
    err_d   = err_q;

    case (state_q)
      ST_INIT: begin
        // Baseline is taken from s1, i.e. the value code will present on the
        // first tracking cycle, so the pipeline is full when tracking starts.
        if (fill_q == FILL_LAST) begin
          prev_d  = s1_q;
          fill_d  = 2'd0;
          state_d = ST_TRACK;
        end else begin
          fill_d = fill_q + 2'd1;
        end
      end
      ST_TRACK, ST_FAULT: begin
        if (clr) begin
          pos_d   = '0;
          fault_d = 1'b0;
          err_d   = '0;
          prev_d  = code;
          state_d = ST_TRACK;
        end else if (code_ok) begin
          prev_d = code;
          case (delta)
            3'd0: begin
            end
            3'd1: begin
              up_d  = 1'b1;
              dir_d = 1'b1;
              pos_d = pos_q + POS_W'(1);
            end
            3'd7: begin
              down_d = 1'b1;
              dir_d  = 1'b0;
              pos_d  = pos_q - POS_W'(1);
            end
            default: begin
              fault_d = 1'b1;
              if (err_q != '1) begin
                err_d = err_q + ERRCNT_W'(1);
              end
              state_d = ST_FAULT;
            end
          endcase
        end
      end
      default: begin
        state_d = ST_INIT;
        fill_d  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      fill_q  <= 2'd0;
      s1_q    <= 3'd0;
      s2_q    <= 3'd0;
`ifdef MONITOR_DEBOUNCE_EN
      s3_q    <= 3'd0;
`endif
      prev_q  <= 3'd0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      dir_q   <= 1'b1;
      pos_q   <= '0;
      fault_q <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
`ifdef MONITOR_DEBOUNCE_EN
      s3_q    <= s3_d;
`endif
      prev_q  <= prev_d;
      up_q    <= up_d;
      down_q  <= down_d;
      dir_q   <= dir_d;
      pos_q   <= pos_d;
      fault_q <= fault_d;
      err_q   <= err_d;
    end
  end

  assign up_step   = up_q;
  assign down_step = down_q;
  assign dir_out   = dir_q;
  assign pos       = pos_q;
  assign fault     = fault_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_count_monitor.sv
// tb/tb_count_monitor.sv - table-driven bench for count_monitor (16-bit and 4-bit position instances).
module tb_count_monitor;

  logic        clkin = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  bus   = 3'd3;
  logic        clr   = 1'b0;

  logic        up_step, down_step, dir_out, fault;
  logic [15:0] pos;
  logic [7:0]  err_cnt;
  logic        up4, dn4, dir4, flt4;
  logic [3:0]  pos4;
  logic [7:0]  err4;

  int total = 0;
  int bad   = 0;

  always #5 clkin = ~clkin;

  count_monitor #(.POS_W(16), .ERRCNT_W(8)) dut (
    .clkin(clkin), .reset(reset), .x0(bus[0]), .x1(bus[1]), .x2(bus[2]), .clr(clr),
    .up_step(up_step), .down_step(down_step), .dir_out(dir_out), .pos(pos),
    .fault(fault), .err_cnt(err_cnt)
  );

  count_monitor #(.POS_W(4), .ERRCNT_W(8)) dut4 (
    .clkin(clkin), .reset(reset), .x0(bus[0]), .x1(bus[1]), .x2(bus[2]), .clr(clr),
    .up_step(up4), .down_step(dn4), .dir_out(dir4), .pos(pos4),
    .fault(flt4), .err_cnt(err4)
  );

  typedef struct {
    logic [2:0]  bus;
    bit          clr;
    int          hold;
    bit          up;
    bit          dn;
    logic [15:0] pos;
    bit          dir;
    bit          flt;
    logic [7:0]  err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " up"},   32'(up_step),   32'd0);
    chk({tag, " dn"},   32'(down_step), 32'd0);
    chk({tag, " dir"},  32'(dir_out),   32'd1);
    chk({tag, " pos"},  32'(pos),       32'd0);
    chk({tag, " flt"},  32'(fault),     32'd0);
    chk({tag, " err"},  32'(err_cnt),   32'd0);
    chk({tag, " pos4"}, 32'(pos4),      32'd0);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clkin);
      @(negedge clkin);
    end
  endtask

  task automatic add(input logic [2:0] b, input bit c, input bit u, input bit d,
                     input logic [15:0] p, input bit dr, input bit f, input logic [7:0] e);
    tbl.push_back('{b, c, 4, u, d, p, dr, f, e});
  endtask

  initial begin
    bit          exp_up, exp_dn, cur_dir, cur_flt;
    logic [15:0] cur_pos;
    logic [7:0]  cur_err;

    // hold 0 while init finishes, then nine up-steps with wrap 7->0
    add(3'd0, 0, 0, 0, 16'h0000, 1, 0, 8'd0);
    add(3'd1, 0, 1, 0, 16'h0001, 1, 0, 8'd0);
    add(3'd2, 0, 1, 0, 16'h0002, 1, 0, 8'd0);
    add(3'd3, 0, 1, 0, 16'h0003, 1, 0, 8'd0);
    add(3'd4, 0, 1, 0, 16'h0004, 1, 0, 8'd0);
    add(3'd5, 0, 1, 0, 16'h0005, 1, 0, 8'd0);
    add(3'd6, 0, 1, 0, 16'h0006, 1, 0, 8'd0);
    add(3'd7, 0, 1, 0, 16'h0007, 1, 0, 8'd0);
    add(3'd0, 0, 1, 0, 16'h0008, 1, 0, 8'd0);
    add(3'd1, 0, 1, 0, 16'h0009, 1, 0, 8'd0);
    // clear, then down-steps across 0->7
    add(3'd1, 1, 0, 0, 16'h0000, 1, 0, 8'd0);
    add(3'd0, 0, 0, 1, 16'hFFFF, 0, 0, 8'd0);
    add(3'd7, 0, 0, 1, 16'hFFFE, 0, 0, 8'd0);
    add(3'd6, 0, 0, 1, 16'hFFFD, 0, 0, 8'd0);
    add(3'd5, 0, 0, 1, 16'hFFFC, 0, 0, 8'd0);
    add(3'd4, 0, 0, 1, 16'hFFFB, 0, 0, 8'd0);
    add(3'd3, 0, 0, 1, 16'hFFFA, 0, 0, 8'd0);
    add(3'd2, 0, 0, 1, 16'hFFF9, 0, 0, 8'd0);
    // illegal 2->5, legal step while faulted, clr swallows 6->7
    add(3'd5, 0, 0, 0, 16'hFFF9, 0, 1, 8'd1);
    add(3'd6, 0, 1, 0, 16'hFFFA, 1, 1, 8'd1);
    add(3'd7, 1, 0, 0, 16'h0000, 1, 0, 8'd0);
    add(3'd0, 0, 1, 0, 16'h0001, 1, 0, 8'd0);
    add(3'd7, 0, 0, 1, 16'h0000, 0, 0, 8'd0);
    // eight up-steps: 4-bit instance goes +7 then -8
    add(3'd0, 0, 1, 0, 16'h0001, 1, 0, 8'd0);
    add(3'd1, 0, 1, 0, 16'h0002, 1, 0, 8'd0);
    add(3'd2, 0, 1, 0, 16'h0003, 1, 0, 8'd0);
    add(3'd3, 0, 1, 0, 16'h0004, 1, 0, 8'd0);
    add(3'd4, 0, 1, 0, 16'h0005, 1, 0, 8'd0);
    add(3'd5, 0, 1, 0, 16'h0006, 1, 0, 8'd0);
    add(3'd6, 0, 1, 0, 16'h0007, 1, 0, 8'd0);
    add(3'd7, 0, 1, 0, 16'h0008, 1, 0, 8'd0);

    // reset state with bus=3
    cycles(3);
    chk_reset_vals("rst0");
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      chk_reset_vals("hold3");
    end

    // re-reset with bus=0 and run the table
    reset = 1'b0;
    bus   = 3'd0;
    cycles(2);
    reset = 1'b1;
    cur_pos = 16'h0000; cur_dir = 1'b1; cur_flt = 1'b0; cur_err = 8'd0;
    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].hold; c++) begin
        bus = tbl[i].bus;
        clr = (c == 2) && tbl[i].clr;
        @(posedge clkin);
        @(negedge clkin);
        if (c == 2) begin
          cur_pos = tbl[i].pos; cur_dir = tbl[i].dir;
          cur_flt = tbl[i].flt; cur_err = tbl[i].err;
        end
        exp_up = (c == 2) && tbl[i].up;
        exp_dn = (c == 2) && tbl[i].dn;
        chk($sformatf("v%0d.%0d up", i, c),   32'(up_step),   32'(exp_up));
        chk($sformatf("v%0d.%0d dn", i, c),   32'(down_step), 32'(exp_dn));
        chk($sformatf("v%0d.%0d dir", i, c),  32'(dir_out),   32'(cur_dir));
        chk($sformatf("v%0d.%0d pos", i, c),  32'(pos),       32'(cur_pos));
        chk($sformatf("v%0d.%0d flt", i, c),  32'(fault),     32'(cur_flt));
        chk($sformatf("v%0d.%0d err", i, c),  32'(err_cnt),   32'(cur_err));
        chk($sformatf("v%0d.%0d pos4", i, c), 32'(pos4),      32'(cur_pos[3:0]));
      end
    end
    clr = 1'b0;

    // fault then down to pos=5, then asynchronous reset mid-cycle
    bus = 3'd3; cycles(4);
    chk("jump73 flt", 32'(fault), 32'd1);
    chk("jump73 err", 32'(err_cnt), 32'd1);
    bus = 3'd2; cycles(4);
    bus = 3'd1; cycles(4);
    bus = 3'd0; cycles(4);
    chk("pre-rst pos", 32'(pos), 32'd5);
    chk("pre-rst flt", 32'(fault), 32'd1);
    @(posedge clkin);
    #2 reset = 1'b0;
    #1 chk_reset_vals("async");

    // glitch 2->6->2
    bus = 3'd2;
    cycles(2);
    reset = 1'b1;
    cycles(6);
    chk("pre-glitch err", 32'(err_cnt), 32'd0);
    bus = 3'd6; cycles(1);
    bus = 3'd2; cycles(6);
    chk("glitch pos", 32'(pos), 32'd0);
`ifdef MONITOR_DEBOUNCE_EN
    chk("glitch flt", 32'(fault), 32'd0);
    chk("glitch err", 32'(err_cnt), 32'd0);
`else
    chk("glitch flt", 32'(fault), 32'd1);
    chk("glitch err", 32'(err_cnt), 32'd2);
`endif

    // 300 illegal jumps saturate the counter
    for (int i = 0; i < 300; i++) begin
      bus = bus ^ 3'd4;
      cycles(2);
    end
    cycles(4);
    chk("sat err", 32'(err_cnt), 32'd255);
    chk("sat err4", 32'(err4), 32'd255);
    chk("sat flt", 32'(fault), 32'd1);
    chk("sat pos", 32'(pos), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  always @(negedge clkin) begin
    if (up_step && down_step) begin
      bad++;
      $display("FAIL both_pulses: got up=1 down=1 expected at most one at %0t", $time);
    end
  end

endmodule
